// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and default sizing for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    localparam int CNT_W_DEF       = 16;
    localparam int TO_W_DEF        = 8;
    localparam int MEM_TIMEOUT_DEF = 200;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: merges load-use bubbles, branch flushes and
// data-memory miss freezes, owns the memory-wait handshake and miss timeout.
//
// state    | meaning
// IDLE     | pipeline held, waiting for start_i
// RUN      | normal execution, priority mux active
// MEM_WAIT | whole pipeline frozen, backing memory requested
// HALT     | memory timeout fault, left only through reset
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TO_W        = TO_W_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             load_use_i,
    input  logic             branch_taken_i,
    input  logic             dmiss_i,
    input  logic             mem_ack_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             back_we_o,
    output logic             mem_req_o,
    output logic             mem_err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Wait count equal to this value marks the last allowed MEM_WAIT cycle.
    localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e          state_d, state_q;
    logic            pend_d, pend_q;
    logic            err_d, err_q;
    logic            mem_req_d, mem_req_q;
    logic            wait_inc, wait_clr;
    logic            stall_inc;
    logic [TO_W-1:0] wait_cnt;

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        err_d         = err_q;
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        back_we_o     = 1'b0;
        wait_inc      = 1'b0;
        wait_clr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (dmiss_i) begin
                    state_d  = ST_MEM_WAIT;
                    wait_clr = 1'b1;
                    if (branch_taken_i && !load_use_i) begin
                        pend_d = 1'b1;
                    end
                end else if (load_use_i) begin
                    // Branch is dropped here; ID re-resolves it next cycle.
                    idex_bubble_o = 1'b1;
                    back_we_o     = 1'b1;
                end else begin
                    pc_we_o   = 1'b1;
                    ifid_we_o = 1'b1;
                    back_we_o = 1'b1;
                    if (branch_taken_i || pend_q) begin
                        ifid_flush_o = 1'b1;
                        pend_d       = 1'b0;
                    end
                end
            end
            ST_MEM_WAIT: begin
                wait_inc = 1'b1;
                if (mem_ack_i) begin
                    state_d  = ST_RUN;
                    wait_clr = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_req_d = (state_q == ST_MEM_WAIT) && (state_d == ST_MEM_WAIT);
        stall_inc = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !pc_we_o;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            mem_req_q <= mem_req_d;
        end
    end

    sat_counter #(.W(TO_W)) u_wait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (wait_inc),
        .clr_i (wait_clr),
        .cnt_o (wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stall_inc),
        .clr_i (1'b0),
        .cnt_o (stall_cnt_o)
    );

    assign mem_req_o = mem_req_q;
    assign mem_err_o = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench: driver pushes per-cycle expectations from a behavioural model,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W = 4;
    localparam int TO_W  = 8;
    localparam int TMO   = 10;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             start_i = 1'b0;
    logic             load_use_i = 1'b0;
    logic             branch_taken_i = 1'b0;
    logic             dmiss_i = 1'b0;
    logic             mem_ack_i = 1'b0;
    logic             pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, back_we_o;
    logic             mem_req_o, mem_err_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .TO_W(TO_W), .MEM_TIMEOUT(TMO)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .load_use_i     (load_use_i),
        .branch_taken_i (branch_taken_i),
        .dmiss_i        (dmiss_i),
        .mem_ack_i      (mem_ack_i),
        .pc_we_o        (pc_we_o),
        .ifid_we_o      (ifid_we_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .back_we_o      (back_we_o),
        .mem_req_o      (mem_req_o),
        .mem_err_o      (mem_err_o),
        .state_o        (state_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]       en;   // {pc_we, ifid_we, ifid_flush, idex_bubble, back_we}
        logic             mem_req;
        logic             mem_err;
        logic [1:0]       st;
        logic [CNT_W-1:0] stall;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: state as a small integer, wait as "cycles spent waiting".
    int m_st, m_pend, m_waited, m_err, m_stall;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_st = 0; m_pend = 0; m_waited = 0; m_err = 0; m_stall = 0;
    endtask

    task automatic step(input bit s, input bit lu, input bit br, input bit dm, input bit ack);
        exp_t e;
        int pc, ifd, fl, bub, bk;
        @(posedge clk_i);
        #1;
        start_i = s; load_use_i = lu; branch_taken_i = br; dmiss_i = dm; mem_ack_i = ack;
        pc = 0; ifd = 0; fl = 0; bub = 0; bk = 0;
        if (m_st == 1 && !dm) begin
            if (lu) begin
                bub = 1; bk = 1;
            end else begin
                pc = 1; ifd = 1; bk = 1;
                fl = (br || m_pend) ? 1 : 0;
            end
        end
        e.en      = {pc[0], ifd[0], fl[0], bub[0], bk[0]};
        e.mem_req = (m_st == 2 && m_waited >= 1);
        e.mem_err = m_err[0];
        e.st      = m_st[1:0];
        e.stall   = m_stall[CNT_W-1:0];
        sb_q.push_back(e);
        if ((m_st == 1 || m_st == 2) && pc == 0 && m_stall < (1 << CNT_W) - 1) m_stall++;
        case (m_st)
            0: if (s) m_st = 1;
            1: begin
                if (dm) begin
                    m_st = 2; m_waited = 0;
                    if (br && !lu) m_pend = 1;
                end else if (fl) begin
                    m_pend = 0;
                end
            end
            2: begin
                m_waited++;
                if (ack) m_st = 1;
                else if (m_waited == TMO) begin m_st = 3; m_err = 1; end
            end
            default: ;
        endcase
    endtask

    // Async reset dropped mid-cycle; outputs must clear before any clock edge.
    task automatic reset_mid();
        @(posedge clk_i);
        #3;
        start_i = 0; load_use_i = 0; branch_taken_i = 0; dmiss_i = 0; mem_ack_i = 0;
        rst_i = 0;
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        chk("rst_mem_err", mem_err_o, 0);
        chk("rst_enables", {pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, back_we_o}, 0);
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1;
    endtask

    always @(negedge clk_i) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("enables", {pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, back_we_o}, mon_e.en);
            chk("mem_req", mem_req_o, mon_e.mem_req);
            chk("mem_err", mem_err_o, mon_e.mem_err);
            chk("state", state_o, mon_e.st);
            chk("stall_cnt", stall_cnt_o, mon_e.stall);
        end
    end

    initial begin
        int halt_cycles;
        model_reset();
        #12;
        chk("init_state", state_o, 0);
        chk("init_enables", {pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, back_we_o, mem_req_o}, 0);
        @(negedge clk_i);
        rst_i = 1;

        // start, then plain running
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        // single load-use bubble
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // branch with miss, deferred flush after the ack
        step(0, 0, 1, 1, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0);
        // load-use and branch together
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // miss with no ack until timeout, then stuck in HALT
        step(0, 0, 0, 1, 0);
        repeat (TMO + 2) step(0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1);
        step(1, 0, 0, 0, 1);
        reset_mid();
        // reset in the middle of MEM_WAIT
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        reset_mid();
        // ack in the same cycle as the timeout boundary
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        repeat (TMO - 1) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        // drive stall count into saturation
        repeat (20) step(0, 1, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        reset_mid();

        halt_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_st == 3) halt_cycles++;
            if (halt_cycles > 3 || $urandom_range(0, 149) == 0) begin
                halt_cycles = 0;
                reset_mid();
            end else begin
                step($urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 3) == 0);
            end
        end

        repeat (2) @(posedge clk_i);
        chk("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
